fisica_pajarito: RTL and testbench
==================================

// Module: fisica_pajarito
// PURPOSE
//  Parametrised bird-motion engine for the flappy game, with velocity state.
//  Flap sets an upward impulse. Gravity accelerates the bird down to a terminal speed.
//  Position is clamped to the play-field; reaching the floor ends the game.
//  Sits between the input/timer logic (flap, frame tick, pause) and the VGA renderer/collision unit.
// PARAMETERS
//  Y_W        10   position width (unsigned pixels)
//  V_W        8    velocity width (two's complement, pixels/tick)
//  Y_INIT     150  start/restart position
//  Y_MIN      0    ceiling clamp (top pixel)
//  Y_MAX      440  floor; reaching it = crash
//  GRAVITY    1    velocity increment per tick
//  FLAP_VEL   -12  velocity loaded on a flap (signed)
//  V_MAX_FALL 8    terminal downward velocity
// PORTS
//  clk          in   1    system clock
//  rst          in   1    async active-low reset
//  en_time_out  in   1    physics tick, 1-cycle pulse per frame
//  en_subiendo  in   1    flap button, level, synchronous; rising edge = flap request
//  pausa        in   1    freeze physics while high
//  inicio       in   1    start/restart pulse
//  posy         out  Y_W  bird top y-coordinate
//  vely         out  V_W  current velocity, signed (+ = down)
//  estado       out  2    00 ESPERA, 01 VUELO, 10 MUERTO
//  choque       out  1    1-cycle pulse on floor hit
// BEHAVIOUR
//  Reset (rst=0, async)
//   - posy=Y_INIT, vely=0, estado=ESPERA, choque=0.
//   - Flap latch and edge register cleared.
//   - Applies immediately, including mid-flight.
//  Flap latch
//   - Edge register samples en_subiendo every cycle.
//   - A rising edge sets flap_pend.
//   - Cleared when consumed by a tick, on inicio, or in any cycle pausa=1 (flaps during pause are dropped).
//   - An edge in the same cycle as a tick counts for that tick.
//  ESPERA
//   - posy held at Y_INIT, vely=0, ticks ignored.
//   - inicio -> VUELO next cycle.
//  VUELO, tick with pausa=0
//   - Velocity update:
//     - if flap_pend (or edge this cycle): v' = FLAP_VEL
//     - else: v' = min(vely+GRAVITY, V_MAX_FALL)
//   - p' = posy + v', computed signed at Y_W+2 bits (no wrap).
//   - Clamp:
//     - p' <= Y_MIN -> posy=Y_MIN, vely=0 (ceiling: no death).
//     - p' >= Y_MAX -> posy=Y_MAX, vely=0, estado=MUERTO, choque=1 for one cycle.
//     - else posy=p', vely=v'.
//   - All updates take effect on the tick edge: latency 1 cycle.
//  VUELO, other cycles
//   - No tick, or pausa=1: posy and vely hold.
//  MUERTO
//   - posy and vely hold; ticks and flaps ignored.
//   - inicio -> VUELO with posy=Y_INIT, vely=0.
//  inicio
//   - In any state: posy=Y_INIT, vely=0, estado=VUELO, flap_pend cleared.
//   - inicio beats a same-cycle tick; no physics is applied that cycle.
//  choque
//   - Asserted only on the transition into MUERTO, never held.
// TESTING
//  T1 Free fall
//   - rst, inicio, 3 ticks, no flap.
//   - vely 1,2,3; posy 151,153,156.
//  T2 Flap
//   - From VUELO posy=150 vely=0: rising edge on en_subiendo, then tick.
//   - vely=-12 (0xF4), posy=138.
//   - Next tick: vely=-11, posy=127.
//  T3 Terminal/ceiling
//   - 10 ticks no flap from 150: vely saturates at 8 from tick 8, posy=150+36+16=202.
//   - Separately: posy=10, flap+tick -> posy=0, vely=0, estado stays 01.
//  T4 Floor crash
//   - Fall until p' >= 440.
//   - posy=440, vely=0, estado=10, choque high exactly 1 cycle.
//   - Further ticks/flaps: no change.
//   - inicio -> posy=150, estado=01.
//  T5 Pause
//   - pausa=1 over 5 ticks with a flap edge inside: posy/vely unchanged.
//   - Release, tick: gravity step (no flap applied).
//  T6 Reset/simultaneous
//   - rst low mid-cycle in VUELO: outputs reset immediately.
//   - inicio+tick same cycle: posy=150, vely=0.

Source files
------------

// File: rtl/fisica_pajarito_if.sv
// Bird-motion engine bus: control inputs from the input/timer logic and the
// bird state toward the renderer and collision unit.
interface fisica_pajarito_if #(
  parameter int Y_W = 10,
  parameter int V_W = 8
);
  logic           en_time_out;  // physics tick, one cycle per frame
  logic           en_subiendo;  // flap button level
  logic           pausa;        // freeze physics
  logic           inicio;       // start/restart pulse
  logic [Y_W-1:0] posy;         // bird top y-coordinate
  logic [V_W-1:0] vely;         // signed velocity, + = down
  logic [1:0]     estado;       // 00 ESPERA, 01 VUELO, 10 MUERTO
  logic           choque;       // one-cycle floor-hit pulse

  // Controller side: drives the game controls, observes the bird.
  modport master (
    output en_time_out, en_subiendo, pausa, inicio,
    input  posy, vely, estado, choque
  );

  // Engine side.
  modport slave (
    input  en_time_out, en_subiendo, pausa, inicio,
    output posy, vely, estado, choque
  );
endinterface

// File: rtl/fisica_pajarito.sv
// Bird-motion engine: a flap loads an upward impulse, gravity pulls the bird
// down to a terminal speed, position is clamped to the play-field and
// reaching the floor ends the game.
module fisica_pajarito #(
  parameter int Y_W        = 10,
  parameter int V_W        = 8,
  parameter int Y_INIT     = 150,
  parameter int Y_MIN      = 0,
  parameter int Y_MAX      = 440,
  parameter int GRAVITY    = 1,
  parameter int FLAP_VEL   = -12,
  parameter int V_MAX_FALL = 8
) (
  input logic               clk,
  input logic               rst,   // asynchronous, active low
  fisica_pajarito_if.slave  bus
);

  typedef enum logic [1:0] {
    ESPERA = 2'b00,
    VUELO  = 2'b01,
    MUERTO = 2'b10
  } estado_t;

  // Constants resized once so every comparison below is signed and width-exact.
  localparam logic        [Y_W-1:0] YINIT_U = Y_W'(Y_INIT);
  localparam logic signed [Y_W+1:0] YMIN_S  = (Y_W+2)'(Y_MIN);
  localparam logic signed [Y_W+1:0] YMAX_S  = (Y_W+2)'(Y_MAX);
  localparam logic signed [V_W:0]   GRAV_S  = (V_W+1)'(GRAVITY);
  localparam logic signed [V_W:0]   VMAX_S  = (V_W+1)'(V_MAX_FALL);
  localparam logic signed [V_W-1:0] FLAP_S  = V_W'(FLAP_VEL);

  estado_t                estado_q;
  logic        [Y_W-1:0]  posy_q;
  logic signed [V_W-1:0]  vely_q;
  logic                   choque_q;
  logic                   subiendo_q;   // previous en_subiendo for edge detect
  logic                   flap_pend;    // flap requested, waiting for a tick

  logic                   rise;
  logic                   flap_now;
  logic signed [V_W:0]    v_grav;       // one extra bit so +GRAVITY cannot wrap
  logic signed [V_W-1:0]  v_next;
  logic signed [Y_W+1:0]  p_next;       // two extra bits: sign plus headroom

  assign rise     = bus.en_subiendo & ~subiendo_q;
  // An edge arriving in the tick cycle itself still counts for that tick.
  assign flap_now = flap_pend | rise;

  // Candidate velocity and position for the next tick.
  always_comb begin
    // NOTE: every always_comb output gets a value on every path, otherwise a latch is inferred.
    v_grav = {vely_q[V_W-1], vely_q} + GRAV_S;
    v_next = v_grav[V_W-1:0];
    if (flap_now) begin
      v_next = FLAP_S;
    end else if (v_grav > VMAX_S) begin
      v_next = VMAX_S[V_W-1:0];
    end
    p_next = {2'b00, posy_q} + {{(Y_W+2-V_W){v_next[V_W-1]}}, v_next};
  end

  // Game FSM with edge register, flap latch and registered outputs.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      estado_q   <= ESPERA;
      posy_q     <= YINIT_U;
      vely_q     <= '0;
      choque_q   <= 1'b0;
      subiendo_q <= 1'b0;
      flap_pend  <= 1'b0;
    end else begin
      // NOTE: state registers use non-blocking assignment so every register samples pre-edge values.
      subiendo_q <= bus.en_subiendo;
      choque_q   <= 1'b0;
      if (bus.inicio) begin
        // Restart wins over a same-cycle tick: no physics this cycle.
        estado_q  <= VUELO;
        posy_q    <= YINIT_U;
        vely_q    <= '0;
        flap_pend <= 1'b0;
      end else begin
        case (estado_q)
          ESPERA: begin
            posy_q    <= YINIT_U;
            vely_q    <= '0;
            flap_pend <= 1'b0;
          end
          VUELO: begin
            if (bus.pausa) begin
              // Flaps made while paused are dropped.
              flap_pend <= 1'b0;
            end else if (bus.en_time_out) begin
              flap_pend <= 1'b0;
              if (p_next <= YMIN_S) begin
                // Ceiling stops the bird but is not fatal.
                posy_q <= YMIN_S[Y_W-1:0];
                vely_q <= '0;
              end else if (p_next >= YMAX_S) begin
                posy_q   <= YMAX_S[Y_W-1:0];
                vely_q   <= '0;
                estado_q <= MUERTO;
                choque_q <= 1'b1;
              end else begin
                posy_q <= p_next[Y_W-1:0];
                vely_q <= v_next;
              end
            end else if (rise) begin
              flap_pend <= 1'b1;
            end
          end
          MUERTO: begin
            // Frozen until restart; flaps are ignored.
            flap_pend <= 1'b0;
          end
          default: begin
            estado_q  <= ESPERA;
            flap_pend <= 1'b0;
          end
        endcase
      end
    end
  end

  assign bus.posy   = posy_q;
  assign bus.vely   = vely_q;
  assign bus.estado = estado_q;
  assign bus.choque = choque_q;

endmodule

// File: tb/tb_fisica_pajarito.sv
// Self-checking bench for fisica_pajarito: a behavioural model pushes the
// expected bird state into a scoreboard whenever a cycle of stimulus is
// driven; the entry is popped and compared once the DUT has taken that edge.
module tb_fisica_pajarito;

  localparam int Y_W = 10;
  localparam int V_W = 8;

  logic clk = 1'b0;
  logic rst;

  always #5 clk = ~clk;

  fisica_pajarito_if #(.Y_W(Y_W), .V_W(V_W)) bus ();

  fisica_pajarito #(
    .Y_W(Y_W), .V_W(V_W), .Y_INIT(150), .Y_MIN(0), .Y_MAX(440),
    .GRAVITY(1), .FLAP_VEL(-12), .V_MAX_FALL(8)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct {
    int posy;
    int vely;
    int estado;
    bit choque;
  } exp_t;

  exp_t sb[$];
  int   n_checks = 0;
  int   n_pass   = 0;

  // Behavioural model state.
  int   m_posy, m_vely, m_est;
  bit   m_choque, m_pend, m_q;

  task automatic model_reset();
    m_posy = 150; m_vely = 0; m_est = 0; m_choque = 0; m_pend = 0; m_q = 0;
  endtask

  // Advance the model by one clock edge with the given inputs and queue the result.
  task automatic model_push(input bit tick, input bit sub, input bit pau, input bit ini);
    exp_t e;
    bit   rise;
    int   v, p;
    rise     = sub && !m_q;
    m_choque = 0;
    if (ini) begin
      m_posy = 150; m_vely = 0; m_est = 1; m_pend = 0;
    end else if (m_est == 1) begin
      if (pau) begin
        m_pend = 0;
      end else if (tick) begin
        if (m_pend || rise) v = -12;
        else v = (m_vely + 1 > 8) ? 8 : m_vely + 1;
        p = m_posy + v;
        if (p <= 0) begin
          m_posy = 0; m_vely = 0;
        end else if (p >= 440) begin
          m_posy = 440; m_vely = 0; m_est = 2; m_choque = 1;
        end else begin
          m_posy = p; m_vely = v;
        end
        m_pend = 0;
      end else if (rise) begin
        m_pend = 1;
      end
    end else begin
      m_pend = 0;
    end
    m_q = sub;
    e.posy = m_posy; e.vely = m_vely; e.estado = m_est; e.choque = m_choque;
    sb.push_back(e);
  endtask

  // One clock of stimulus: drive, queue the expectation, take the edge, pop and compare.
  task automatic step(input string name, input bit tick, input bit sub,
                      input bit pau, input bit ini);
    exp_t       e;
    logic [20:0] got, want;
    bus.en_time_out = tick;
    bus.en_subiendo = sub;
    bus.pausa       = pau;
    bus.inicio      = ini;
    model_push(tick, sub, pau, ini);
    @(posedge clk);
    #1;
    bus.en_time_out = 1'b0;
    bus.inicio      = 1'b0;
    n_checks++;
    if (sb.size() == 0) begin
      $display("FAIL %s: scoreboard empty, nothing to compare", name);
    end else begin
      e    = sb.pop_front();
      got  = {bus.posy, bus.vely, bus.estado, bus.choque};
      want = {10'(e.posy), 8'(e.vely), 2'(e.estado), e.choque};
      if (got !== want)
        $display("FAIL %s: got posy=%0d vely=%0d estado=%0d choque=%0b, want posy=%0d vely=%0d estado=%0d choque=%0b",
                 name, bus.posy, $signed(bus.vely), bus.estado, bus.choque,
                 e.posy, e.vely, e.estado, e.choque);
      else
        n_pass++;
    end
  endtask

  // Pull reset low away from the clock edge and check that it acts at once.
  task automatic do_reset(input string name);
    rst = 1'b0;
    #2;
    model_reset();
    n_checks++;
    if ({bus.posy, bus.vely, bus.estado, bus.choque} !== {10'd150, 8'd0, 2'b00, 1'b0})
      $display("FAIL %s: got posy=%0d vely=%0d estado=%0d choque=%0b, want 150 0 0 0",
               name, bus.posy, $signed(bus.vely), bus.estado, bus.choque);
    else
      n_pass++;
    @(posedge clk);
    #1;
    rst = 1'b1;
  endtask

  task automatic test_reset();
    do_reset("reset_state");
    // Ticks in ESPERA are ignored.
    step("espera_tick", 1, 0, 0, 0);
    step("espera_flap_tick", 1, 1, 0, 0);
    step("espera_idle", 0, 0, 0, 0);
  endtask

  task automatic test_free_fall();
    int exp_p[3] = '{151, 153, 156};
    int exp_v[3] = '{1, 2, 3};
    do_reset("ff_reset");
    step("ff_inicio", 0, 0, 0, 1);
    n_checks++;
    if (bus.estado !== 2'b01 || bus.posy !== 10'd150)
      $display("FAIL ff_start: got estado=%0d posy=%0d, want 1 150", bus.estado, bus.posy);
    else
      n_pass++;
    for (int i = 0; i < 3; i++) begin
      step("ff_tick", 1, 0, 0, 0);
      n_checks++;
      if (bus.posy !== 10'(exp_p[i]) || $signed(bus.vely) !== exp_v[i])
        $display("FAIL ff_value[%0d]: got posy=%0d vely=%0d, want %0d %0d",
                 i, bus.posy, $signed(bus.vely), exp_p[i], exp_v[i]);
      else
        n_pass++;
    end
  endtask

  task automatic test_flap();
    step("fl_inicio", 0, 0, 0, 1);
    step("fl_edge", 0, 1, 0, 0);        // edge latched, no tick yet
    step("fl_hold", 0, 1, 0, 0);        // still pending, nothing moves
    step("fl_tick", 1, 1, 0, 0);
    n_checks++;
    if (bus.vely !== 8'hF4 || bus.posy !== 10'd138)
      $display("FAIL flap_impulse: got vely=0x%0h posy=%0d, want 0xf4 138", bus.vely, bus.posy);
    else
      n_pass++;
    step("fl_release", 0, 0, 0, 0);
    step("fl_grav", 1, 0, 0, 0);
    n_checks++;
    if ($signed(bus.vely) !== -11 || bus.posy !== 10'd127)
      $display("FAIL flap_next: got vely=%0d posy=%0d, want -11 127", $signed(bus.vely), bus.posy);
    else
      n_pass++;
    // Edge arriving in the same cycle as the tick.
    step("fl_same_cycle", 1, 1, 0, 0);
    n_checks++;
    if ($signed(bus.vely) !== -12 || bus.posy !== 10'd115)
      $display("FAIL flap_same_cycle: got vely=%0d posy=%0d, want -12 115", $signed(bus.vely), bus.posy);
    else
      n_pass++;
    step("fl_release2", 0, 0, 0, 0);
  endtask

  task automatic test_terminal_ceiling();
    int guard;
    step("tc_inicio", 0, 0, 0, 1);
    for (int i = 0; i < 10; i++) step("tc_tick", 1, 0, 0, 0);
    n_checks++;
    if ($signed(bus.vely) !== 8 || bus.posy !== 10'd202)
      $display("FAIL terminal: got vely=%0d posy=%0d, want 8 202", $signed(bus.vely), bus.posy);
    else
      n_pass++;
    // Flap up until the next impulse would cross the ceiling.
    step("tc_inicio2", 0, 0, 0, 1);
    guard = 0;
    while (m_posy >= 12 && guard < 30) begin
      step("tc_low", 0, 0, 0, 0);
      step("tc_flap", 1, 1, 0, 0);
      guard++;
    end
    step("tc_low2", 0, 0, 0, 0);
    step("tc_ceiling", 1, 1, 0, 0);
    n_checks++;
    if (bus.posy !== 10'd0 || bus.vely !== 8'd0 || bus.estado !== 2'b01)
      $display("FAIL ceiling: got posy=%0d vely=%0d estado=%0d, want 0 0 1",
               bus.posy, $signed(bus.vely), bus.estado);
    else
      n_pass++;
    step("tc_release", 0, 0, 0, 0);
  endtask

  task automatic test_crash();
    int ticks;
    step("cr_inicio", 0, 0, 0, 1);
    ticks = 0;
    while (bus.estado !== 2'b10 && ticks < 100) begin
      step("cr_fall", 1, 0, 0, 0);
      ticks++;
    end
    n_checks++;
    if (bus.estado !== 2'b10 || bus.choque !== 1'b1 || bus.posy !== 10'd440 || bus.vely !== 8'd0)
      $display("FAIL crash: got estado=%0d choque=%0b posy=%0d vely=%0d after %0d ticks, want 2 1 440 0",
               bus.estado, bus.choque, bus.posy, $signed(bus.vely), ticks);
    else
      n_pass++;
    step("cr_after", 0, 0, 0, 0);
    n_checks++;
    if (bus.choque !== 1'b0)
      $display("FAIL choque_pulse: got choque=%0b one cycle after crash, want 0", bus.choque);
    else
      n_pass++;
    step("cr_dead_tick", 1, 0, 0, 0);
    step("cr_dead_flap", 1, 1, 0, 0);
    step("cr_dead_tick2", 1, 0, 0, 0);
    step("cr_restart", 0, 0, 0, 1);
    n_checks++;
    if (bus.posy !== 10'd150 || bus.estado !== 2'b01 || bus.vely !== 8'd0)
      $display("FAIL crash_restart: got posy=%0d estado=%0d vely=%0d, want 150 1 0",
               bus.posy, bus.estado, $signed(bus.vely));
    else
      n_pass++;
  endtask

  task automatic test_pause();
    logic [9:0] p0;
    logic [7:0] v0;
    step("pa_inicio", 0, 0, 0, 1);
    step("pa_t1", 1, 0, 0, 0);
    step("pa_t2", 1, 0, 0, 0);
    p0 = bus.posy;
    v0 = bus.vely;
    for (int i = 0; i < 5; i++) begin
      step("pa_tick", 1, (i >= 2), 1, 0);   // flap edge lands inside the pause
      step("pa_gap", 0, (i >= 2), 1, 0);
    end
    n_checks++;
    if (bus.posy !== p0 || bus.vely !== v0)
      $display("FAIL pause_hold: got posy=%0d vely=%0d, want %0d %0d",
               bus.posy, $signed(bus.vely), p0, $signed(v0));
    else
      n_pass++;
    step("pa_resume", 1, 1, 0, 0);
    n_checks++;
    if (bus.posy !== 10'd156 || $signed(bus.vely) !== 3)
      $display("FAIL pause_resume: got posy=%0d vely=%0d, want 156 3", bus.posy, $signed(bus.vely));
    else
      n_pass++;
    step("pa_release", 0, 0, 0, 0);
  endtask

  task automatic test_back_to_back();
    step("bb_t1", 1, 0, 0, 0);
    step("bb_inicio_tick", 1, 0, 0, 1);
    n_checks++;
    if (bus.posy !== 10'd150 || bus.vely !== 8'd0 || bus.estado !== 2'b01)
      $display("FAIL inicio_beats_tick: got posy=%0d vely=%0d estado=%0d, want 150 0 1",
               bus.posy, $signed(bus.vely), bus.estado);
    else
      n_pass++;
    step("bb_t2", 1, 0, 0, 0);
    step("bb_t3", 1, 0, 0, 0);
    // Reset mid-flight, half way between edges.
    do_reset("midflight_reset");
    step("bb_after_reset", 1, 0, 0, 0);
  endtask

  initial begin
    rst             = 1'b0;
    bus.en_time_out = 1'b0;
    bus.en_subiendo = 1'b0;
    bus.pausa       = 1'b0;
    bus.inicio      = 1'b0;
    model_reset();
    @(posedge clk);
    #1;
    test_reset();
    test_free_fall();
    test_flap();
    test_terminal_ceiling();
    test_crash();
    test_pause();
    test_back_to_back();
    n_checks++;
    if (sb.size() != 0)
      $display("FAIL scoreboard_drain: %0d entries left, want 0", sb.size());
    else
      n_pass++;
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  // Hard time limit so the run can never hang.
  initial begin
    #500000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

endmodule
